// File: rtl/cpu_ctl_pkg.sv
// Shared control-sequencer types: state encoding,
// default opcodes, ALU codes and the strobe bundle.
package cpu_ctl_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    T0   = 3'd1,
    T1   = 3'd2,
    T2   = 3'd3,
    T3   = 3'd4,
    T4   = 3'd5,
    T5   = 3'd6,
    T6   = 3'd7
  } state_t;

  localparam logic [4:0] DEF_OPC_JAL = 5'b10100;
  localparam logic [4:0] DEF_OPC_JR  = 5'b10011;
  localparam logic [4:0] DEF_OPC_BR  = 5'b10010;

  localparam logic [4:0] DEF_ALU_ADD = 5'b00001;

  typedef struct packed {
    logic pc_out;
    logic pc_in;
    logic inc_pc;
    logic mar_in;
    logic mdr_read;
    logic mdr_in;
    logic mdr_out;
    logic ir_in;
    logic y_in;
    logic c_out;
    logic z_in;
    logic zlow_out;
    logic gra;
    logic grb;
    logic r_in;
    logic r_out;
    logic conff_in;
    logic done;
    logic illegal;
  } ctl_t;

  // T index seen by the outside world; IDLE reads as 0
  function automatic logic [2:0] step_of(state_t s);
    if (s == IDLE) return 3'd0;
    return 3'(s) - 3'd1;
  endfunction

endpackage

// File: rtl/jump_ctl_seq_decode.sv
// Combinational strobe decode from the current
// T-step, the latched opcode and the CON FF.
module ctl_decode
  import cpu_ctl_pkg::*;
#(
  parameter int OPC_W = 5,
  parameter logic [OPC_W-1:0] OPC_JAL =
    OPC_W'(DEF_OPC_JAL),
  parameter logic [OPC_W-1:0] OPC_JR =
    OPC_W'(DEF_OPC_JR),
  parameter logic [OPC_W-1:0] OPC_BR =
    OPC_W'(DEF_OPC_BR),
  parameter int ALU_W = 5,
  parameter logic [ALU_W-1:0] ALU_ADD =
    ALU_W'(DEF_ALU_ADD)
) (
  input  state_t           state,
  input  logic [OPC_W-1:0] opc,
  input  logic             con_ff,
  output ctl_t             ctl,
  output logic [ALU_W-1:0] alu_sel
);

  logic is_jal;
  logic is_jr;
  logic is_br;

  assign is_jal = (opc == OPC_JAL);
  assign is_jr  = (opc == OPC_JR);
  assign is_br  = (opc == OPC_BR);

  always_comb begin
    ctl     = '0;
    alu_sel = '0;
    unique case (state)
      IDLE: ;
      T0: begin
        ctl.pc_out = 1'b1;
        ctl.mar_in = 1'b1;
        ctl.inc_pc = 1'b1;
        ctl.z_in   = 1'b1;
      end
      T1: begin
        ctl.zlow_out = 1'b1;
        ctl.pc_in    = 1'b1;
        ctl.mdr_read = 1'b1;
        ctl.mdr_in   = 1'b1;
      end
      T2: begin
        ctl.mdr_out = 1'b1;
        ctl.ir_in   = 1'b1;
      end
      T3: begin
        if (is_jal) begin
          ctl.grb    = 1'b1;
          ctl.r_in   = 1'b1;
          ctl.pc_out = 1'b1;
        end else if (is_jr) begin
          ctl.gra   = 1'b1;
          ctl.r_out = 1'b1;
          ctl.pc_in = 1'b1;
          ctl.done  = 1'b1;
        end else if (is_br) begin
          ctl.gra      = 1'b1;
          ctl.r_out    = 1'b1;
          ctl.conff_in = 1'b1;
        end else begin
          ctl.illegal = 1'b1;
        end
      end
      T4: begin
        if (is_jal) begin
          ctl.gra   = 1'b1;
          ctl.r_out = 1'b1;
          ctl.pc_in = 1'b1;
          ctl.done  = 1'b1;
        end else if (is_br) begin
          ctl.pc_out = 1'b1;
          ctl.y_in   = 1'b1;
        end
      end
      T5: begin
        ctl.grb   = 1'b1;
        ctl.r_out = 1'b1;
        ctl.c_out = 1'b1;
        ctl.z_in  = 1'b1;
        alu_sel   = ALU_ADD;
      end
      T6: begin
        ctl.zlow_out = 1'b1;
        ctl.pc_in    = con_ff;
        ctl.done     = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/jump_ctl_seq.sv
// Hardwired T-step sequencer for fetch plus the
// JAL / JR / branch execute steps.
module jump_ctl_seq
  import cpu_ctl_pkg::*;
#(
  parameter int OPC_W = 5,
  parameter logic [OPC_W-1:0] OPC_JAL =
    OPC_W'(DEF_OPC_JAL),
  parameter logic [OPC_W-1:0] OPC_JR =
    OPC_W'(DEF_OPC_JR),
  parameter logic [OPC_W-1:0] OPC_BR =
    OPC_W'(DEF_OPC_BR),
  parameter int ALU_W = 5,
  parameter logic [ALU_W-1:0] ALU_ADD =
    ALU_W'(DEF_ALU_ADD),
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             run,
  input  logic             mem_ready,
  input  logic [31:0]      ir,
  input  logic             con_ff,
  output logic             PCout,
  output logic             PCin,
  output logic             IncPC,
  output logic             MARin,
  output logic             MDRread,
  output logic             MDRin,
  output logic             MDRout,
  output logic             IRin,
  output logic             Yin,
  output logic             Cout,
  output logic             Zin,
  output logic             ZLowout,
  output logic             Gra,
  output logic             Grb,
  output logic             Rin,
  output logic             Rout,
  output logic             conffin,
  output logic [ALU_W-1:0] alu_sel,
  output logic [2:0]       step,
  output logic             busy,
  output logic             done,
  output logic             illegal,
  output logic [CNT_W-1:0] retired
);

  state_t           state;
  logic [OPC_W-1:0] opc;
  logic [CNT_W-1:0] ret_cnt;
  logic             clr_q;
  ctl_t             ctl;
  logic             unused_ir;

  assign unused_ir = ^ir[31-OPC_W:0];

  ctl_decode #(
    .OPC_W  (OPC_W),
    .OPC_JAL(OPC_JAL),
    .OPC_JR (OPC_JR),
    .OPC_BR (OPC_BR),
    .ALU_W  (ALU_W),
    .ALU_ADD(ALU_ADD)
  ) u_dec (
    .state  (state),
    .opc    (opc),
    .con_ff (con_ff),
    .ctl    (ctl),
    .alu_sel(alu_sel)
  );

  // one-edge hold-off so reset release is synchronous
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) clr_q <= 1'b0;
    else      clr_q <= 1'b1;
  end

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state   <= IDLE;
      opc     <= '0;
      ret_cnt <= '0;
    end else if (clr_q) begin
      if (state == T2)
        opc <= ir[31 -: OPC_W];
      if (ctl.done)
        ret_cnt <= ret_cnt + CNT_W'(1);
      unique case (state)
        IDLE: if (run) state <= T0;
        T0:   state <= T1;
        T1:   if (mem_ready) state <= T2;
        T2:   state <= T3;
        default: begin
          if (ctl.done)
            state <= run ? T0 : IDLE;
          else if (ctl.illegal)
            state <= IDLE;
          else
            state <= state_t'(3'(state) + 3'd1);
        end
      endcase
    end
  end

  assign PCout   = ctl.pc_out;
  assign PCin    = ctl.pc_in;
  assign IncPC   = ctl.inc_pc;
  assign MARin   = ctl.mar_in;
  assign MDRread = ctl.mdr_read;
  assign MDRin   = ctl.mdr_in;
  assign MDRout  = ctl.mdr_out;
  assign IRin    = ctl.ir_in;
  assign Yin     = ctl.y_in;
  assign Cout    = ctl.c_out;
  assign Zin     = ctl.z_in;
  assign ZLowout = ctl.zlow_out;
  assign Gra     = ctl.gra;
  assign Grb     = ctl.grb;
  assign Rin     = ctl.r_in;
  assign Rout    = ctl.r_out;
  assign conffin = ctl.conff_in;
  assign done    = ctl.done;
  assign illegal = ctl.illegal;
  assign step    = step_of(state);
  assign busy    = (state != IDLE);
  assign retired = ret_cnt;

endmodule

// File: tb/tb_jump_ctl_seq.sv
// Self-checking bench for jump_ctl_seq: vector table,
// corner sequences and a randomized instruction model.
module tb_jump_ctl_seq;

  logic        clk = 1'b0;
  logic        clr = 1'b1;
  logic        run = 1'b0;
  logic        mem_ready = 1'b1;
  logic        con_ff = 1'b0;
  logic [31:0] ir = 32'h0;

  logic PCout, PCin, IncPC, MARin, MDRread, MDRin;
  logic MDRout, IRin, Yin, Cout, Zin, ZLowout;
  logic Gra, Grb, Rin, Rout, conffin;
  logic [4:0]  alu_sel;
  logic [2:0]  step;
  logic        busy, done, illegal;
  logic [15:0] retired;

  jump_ctl_seq dut (
    .clk(clk), .clr(clr), .run(run),
    .mem_ready(mem_ready), .ir(ir),
    .con_ff(con_ff),
    .PCout(PCout), .PCin(PCin), .IncPC(IncPC),
    .MARin(MARin), .MDRread(MDRread),
    .MDRin(MDRin), .MDRout(MDRout), .IRin(IRin),
    .Yin(Yin), .Cout(Cout), .Zin(Zin),
    .ZLowout(ZLowout), .Gra(Gra), .Grb(Grb),
    .Rin(Rin), .Rout(Rout), .conffin(conffin),
    .alu_sel(alu_sel), .step(step), .busy(busy),
    .done(done), .illegal(illegal),
    .retired(retired)
  );

  always #5 clk = ~clk;

  localparam logic [19:0] M_PCOUT  = 20'h80000;
  localparam logic [19:0] M_PCIN   = 20'h40000;
  localparam logic [19:0] M_INCPC  = 20'h20000;
  localparam logic [19:0] M_MARIN  = 20'h10000;
  localparam logic [19:0] M_MDRRD  = 20'h08000;
  localparam logic [19:0] M_MDRIN  = 20'h04000;
  localparam logic [19:0] M_MDROUT = 20'h02000;
  localparam logic [19:0] M_IRIN   = 20'h01000;
  localparam logic [19:0] M_YIN    = 20'h00800;
  localparam logic [19:0] M_COUT   = 20'h00400;
  localparam logic [19:0] M_ZIN    = 20'h00200;
  localparam logic [19:0] M_ZLOW   = 20'h00100;
  localparam logic [19:0] M_GRA    = 20'h00080;
  localparam logic [19:0] M_GRB    = 20'h00040;
  localparam logic [19:0] M_RIN    = 20'h00020;
  localparam logic [19:0] M_ROUT   = 20'h00010;
  localparam logic [19:0] M_CONFF  = 20'h00008;
  localparam logic [19:0] M_BUSY   = 20'h00004;
  localparam logic [19:0] M_DONE   = 20'h00002;
  localparam logic [19:0] M_ILL    = 20'h00001;

  localparam logic [19:0] V_T0 =
    M_PCOUT | M_MARIN | M_INCPC | M_ZIN | M_BUSY;
  localparam logic [19:0] V_T1 =
    M_ZLOW | M_PCIN | M_MDRRD | M_MDRIN | M_BUSY;
  localparam logic [19:0] V_T2 =
    M_MDROUT | M_IRIN | M_BUSY;

  localparam logic [31:0] IR_JAL = 32'hA1000000;
  localparam logic [31:0] IR_JR  = 32'h98800000;
  localparam logic [31:0] IR_BR  = 32'h90000000;
  localparam logic [31:0] IR_ILL = 32'h00000000;

  logic [19:0] sig;
  assign sig = {PCout, PCin, IncPC, MARin, MDRread,
                MDRin, MDRout, IRin, Yin, Cout, Zin,
                ZLowout, Gra, Grb, Rin, Rout, conffin,
                busy, done, illegal};

  typedef struct {
    logic [31:0] ir;
    logic        con;
    int          t;
    logic [19:0] sig;
    logic [4:0]  alu;
    logic [2:0]  step;
  } vec_t;

  vec_t tbl[$];

  int checks = 0;
  int errors = 0;
  int exp_ret = 0;

  int done_cyc, ill_cyc, inc_cnt, t1_cnt, idle_cnt;
  int ndone, nill, end_cyc, len, wt, kind;
  logic [31:0] dmask;
  logic        pcin_end, exp_pcin, cn;
  logic [4:0]  op;
  logic        b5, b6;

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h",
               name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic vec_t mk(logic [31:0] i,
                              logic c, int t,
                              logic [19:0] s,
                              logic [4:0] a,
                              logic [2:0] st);
    vec_t v;
    v.ir = i; v.con = c; v.t = t;
    v.sig = s; v.alu = a; v.step = st;
    return v;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not end");
    $fatal(1);
  end

  initial begin
    tbl.push_back(mk(IR_JAL, 0, 0, V_T0, 0, 0));
    tbl.push_back(mk(IR_JAL, 0, 1, V_T1, 0, 1));
    tbl.push_back(mk(IR_JAL, 0, 2, V_T2, 0, 2));
    tbl.push_back(mk(IR_JAL, 0, 3,
      M_GRB | M_RIN | M_PCOUT | M_BUSY, 0, 3));
    tbl.push_back(mk(IR_JAL, 0, 4,
      M_GRA | M_ROUT | M_PCIN | M_DONE | M_BUSY, 0, 4));
    tbl.push_back(mk(IR_JAL, 0, 5, 20'h0, 0, 0));
    tbl.push_back(mk(IR_JR, 0, 3,
      M_GRA | M_ROUT | M_PCIN | M_DONE | M_BUSY, 0, 3));
    tbl.push_back(mk(IR_JR, 0, 4, 20'h0, 0, 0));
    tbl.push_back(mk(IR_BR, 1, 3,
      M_GRA | M_ROUT | M_CONFF | M_BUSY, 0, 3));
    tbl.push_back(mk(IR_BR, 1, 4,
      M_PCOUT | M_YIN | M_BUSY, 0, 4));
    tbl.push_back(mk(IR_BR, 1, 5,
      M_GRB | M_ROUT | M_COUT | M_ZIN | M_BUSY,
      5'b00001, 5));
    tbl.push_back(mk(IR_BR, 1, 6,
      M_ZLOW | M_PCIN | M_DONE | M_BUSY, 0, 6));
    tbl.push_back(mk(IR_BR, 0, 6,
      M_ZLOW | M_DONE | M_BUSY, 0, 6));
    tbl.push_back(mk(IR_ILL, 0, 3,
      M_ILL | M_BUSY, 0, 3));
    tbl.push_back(mk(IR_ILL, 0, 4, 20'h0, 0, 0));

    // reset and synchronised release
    ir = IR_JR;
    #2 clr = 1'b0;
    #10;
    chk("rst sig", sig, 0);
    chk("rst step", step, 0);
    chk("rst alu", alu_sel, 0);
    chk("rst retired", retired, 0);
    run = 1'b1;
    @(negedge clk) clr = 1'b1;
    tick;
    chk("rel edge1 busy", busy, 0);
    tick;
    chk("rel edge2 T0", sig, V_T0);
    run = 1'b0;
    repeat (8) tick;
    exp_ret++;
    chk("rel retired", retired, exp_ret);

    // vector table
    for (int i = 0; i < tbl.size(); i++) begin
      ir = tbl[i].ir;
      con_ff = tbl[i].con;
      run = 1'b1;
      tick;
      run = 1'b0;
      repeat (tbl[i].t) tick;
      chk($sformatf("vec%0d sig", i), sig, tbl[i].sig);
      chk($sformatf("vec%0d step", i), step,
          tbl[i].step);
      chk($sformatf("vec%0d alu", i), alu_sel,
          tbl[i].alu);
      repeat (8) tick;
      if (tbl[i].ir != IR_ILL) exp_ret++;
      chk($sformatf("vec%0d retired", i), retired,
          exp_ret);
    end

    // JR with three memory wait cycles
    ir = IR_JR;
    run = 1'b1;
    done_cyc = 0; inc_cnt = 0; t1_cnt = 0;
    for (int k = 1; k <= 12; k++) begin
      mem_ready = (k >= 6);
      tick;
      if (k == 1) run = 1'b0;
      if (IncPC) inc_cnt++;
      if (busy && step == 3'd1) t1_cnt++;
      if (done && done_cyc == 0) done_cyc = k;
    end
    mem_ready = 1'b1;
    exp_ret++;
    chk("wait done cycle", done_cyc, 7);
    chk("wait IncPC count", inc_cnt, 1);
    chk("wait T1 cycles", t1_cnt, 4);
    chk("wait retired", retired, exp_ret);

    // three back-to-back JR with run held
    ir = IR_JR;
    run = 1'b1;
    dmask = 0; idle_cnt = 0;
    for (int k = 1; k <= 12; k++) begin
      tick;
      if (done) dmask[k] = 1'b1;
      if (!busy) idle_cnt++;
    end
    run = 1'b0;
    repeat (4) tick;
    exp_ret += 3;
    chk("b2b done cycles", dmask, 32'h1110);
    chk("b2b idle cycles", idle_cnt, 0);
    chk("b2b retired", retired, exp_ret);

    // illegal opcode with run held
    ir = IR_ILL;
    run = 1'b1;
    ill_cyc = 0; b5 = 1'b1; b6 = 1'b0;
    for (int k = 1; k <= 6; k++) begin
      tick;
      if (illegal && ill_cyc == 0) ill_cyc = k;
      if (k == 5) b5 = busy;
      if (k == 6) b6 = busy && (step == 3'd0);
    end
    run = 1'b0;
    repeat (8) tick;
    chk("ill cycle", ill_cyc, 4);
    chk("ill then idle", b5, 0);
    chk("ill then T0", b6, 1);
    chk("ill retired", retired, exp_ret);

    // retired counter wrap
    force dut.ret_cnt = 16'hFFFF;
    #1;
    release dut.ret_cnt;
    #1;
    chk("wrap preload", retired, 16'hFFFF);
    ir = IR_JR;
    run = 1'b1;
    tick;
    run = 1'b0;
    repeat (6) tick;
    exp_ret = 0;
    chk("wrap retired", retired, exp_ret);

    // asynchronous clear during branch T4
    ir = IR_BR;
    con_ff = 1'b1;
    run = 1'b1;
    repeat (5) tick;
    chk("clr pre step", step, 4);
    #2 clr = 1'b0;
    #1;
    chk("clr sig", sig, 0);
    chk("clr step", step, 0);
    chk("clr alu", alu_sel, 0);
    chk("clr retired", retired, 0);
    exp_ret = 0;
    @(negedge clk) clr = 1'b1;
    tick;
    chk("clr edge1 busy", busy, 0);
    tick;
    chk("clr restart T0", sig, V_T0);
    run = 1'b0;
    repeat (8) tick;
    exp_ret++;
    chk("clr after retired", retired, exp_ret);

    // randomized instruction stream vs model
    for (int n = 0; n < 40; n++) begin
      kind = $urandom_range(0, 3);
      wt = $urandom_range(0, 3);
      cn = 1'($urandom_range(0, 1));
      unique case (kind)
        0: begin op = 5'b10100; len = 5;
                 exp_pcin = 1'b1; end
        1: begin op = 5'b10011; len = 4;
                 exp_pcin = 1'b1; end
        2: begin op = 5'b10010; len = 7;
                 exp_pcin = cn; end
        default: begin
          op = 5'($urandom_range(0, 31));
          while (op == 5'b10100 || op == 5'b10011 ||
                 op == 5'b10010)
            op = 5'($urandom_range(0, 31));
          len = 4;
          exp_pcin = 1'b0;
        end
      endcase
      len += wt;
      ir = {op, 27'($urandom)};
      con_ff = cn;
      run = 1'b1;
      end_cyc = 0; ndone = 0; nill = 0;
      pcin_end = 1'b0;
      for (int k = 1; k <= 14; k++) begin
        mem_ready = (k >= 3 + wt);
        tick;
        if (k == 1) run = 1'b0;
        if (done) ndone++;
        if (illegal) nill++;
        if ((done || illegal) && end_cyc == 0) begin
          end_cyc = k;
          pcin_end = PCin;
        end
      end
      mem_ready = 1'b1;
      if (kind != 3) exp_ret++;
      chk($sformatf("rnd%0d end cycle", n),
          end_cyc, len);
      chk($sformatf("rnd%0d done count", n),
          ndone, (kind != 3) ? 1 : 0);
      chk($sformatf("rnd%0d illegal count", n),
          nill, (kind == 3) ? 1 : 0);
      chk($sformatf("rnd%0d PCin", n),
          pcin_end, exp_pcin);
      chk($sformatf("rnd%0d idle", n), busy, 0);
      chk($sformatf("rnd%0d retired", n),
          retired, exp_ret);
    end

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
